// File: rtl/gpr_wb_arbiter_if.sv
// Writeback bus between the NUM_REQ writeback sources and the arbiter,
// including the register file write port the arbiter drives.
// master: the requester side (drives valid/index/data, observes ready and
//         the register file port).
// slave:  the arbiter side.
interface gpr_wb_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    // Per-requester handshake, payloads packed requester i at [i*W +: W]
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_rdn;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_rdd;
    logic [NUM_REQ-1:0]            req_ready;

    // Register file write port
    logic                          wbe;
    logic [ADDR_WIDTH-1:0]         rdn;
    logic [DATA_WIDTH-1:0]         rdd;

    modport master (
        output req_valid,
        output req_rdn,
        output req_rdd,
        input  req_ready,
        input  wbe,
        input  rdn,
        input  rdd
    );

    modport slave (
        input  req_valid,
        input  req_rdn,
        input  req_rdd,
        output req_ready,
        output wbe,
        output rdn,
        output rdd
    );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Shares the single GPR file write port between NUM_REQ writeback sources.
// One-hot grant is combinational from req_valid and the priority pointer;
// the accepted payload is registered and drives the register file directly,
// giving one cycle of latency and one accept per cycle.
// A saturating counter records cycles with contention (>= 2 valid requests).
//
// Build option: define GPR_WB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (lowest index wins); the priority pointer is then removed.
module gpr_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 3,
    parameter int CNT_WIDTH  = 16,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rstn_h,
    gpr_wb_arbiter_if.slave      wb_if,
    output logic [IDX_W-1:0]     grant_idx,
    input  logic                 clr_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    // ------------------------------------------------------------------
    // Unpacked views of the per-requester payloads
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] req_rdn_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_rdd_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_rdn_arr[gi] = wb_if.req_rdn[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_rdd_arr[gi] = wb_if.req_rdd[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  wbe_q,       wbe_d;
    logic [ADDR_WIDTH-1:0] rdn_q,       rdn_d;
    logic [DATA_WIDTH-1:0] rdd_q,       rdd_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
`ifndef GPR_WB_FIXED_PRIO_EN
    logic [IDX_W-1:0]      ptr_q,       ptr_d;
    logic [IDX_W:0]        rr_sum;
`endif

    // Arbitration results
    logic                  gnt_any;
    logic [IDX_W-1:0]      gnt_idx;
    logic [NUM_REQ-1:0]    gnt_oh;
    logic [IDX_W:0]        valid_cnt;
    logic                  contention;

    // ------------------------------------------------------------------
    // Arbiter: pick the first valid requester at or above the pointer
    // (round-robin) or the lowest valid index (fixed priority). The search
    // runs from the farthest candidate toward the nearest so the nearest
    // valid one is the last to be written and therefore wins.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
`ifdef GPR_WB_FIXED_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (wb_if.req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
`else
        rr_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            rr_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (wb_if.req_valid[rr_sum[IDX_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_sum[IDX_W-1:0];
            end
        end
`endif
        // No grants are issued while the block is held in reset
        if (!rstn_h) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    assign wb_if.req_ready = gnt_oh;

    // Contention detect: two or more requesters valid in the same cycle
    always_comb begin
        valid_cnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            valid_cnt = valid_cnt + (IDX_W+1)'(wb_if.req_valid[k]);
        end
        contention = (valid_cnt >= (IDX_W+1)'(2));
    end

    // ------------------------------------------------------------------
    // Next-state: output register, pointer and contention counter
    // ------------------------------------------------------------------
    always_comb begin
        wbe_d       = 1'b0;
        rdn_d       = rdn_q;
        rdd_d       = rdd_q;
        grant_idx_d = grant_idx_q;
        stall_cnt_d = stall_cnt_q;
`ifndef GPR_WB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif

        if (gnt_any) begin
            // x0 writes complete the handshake but never reach the file
            rdn_d       = req_rdn_arr[gnt_idx];
            rdd_d       = req_rdd_arr[gnt_idx];
            wbe_d       = (req_rdn_arr[gnt_idx] != '0);
            grant_idx_d = gnt_idx;
`ifndef GPR_WB_FIXED_PRIO_EN
            if (gnt_idx == IDX_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + IDX_W'(1);
            end
`endif
        end

        // Clear wins over increment; increment saturates at all ones
        if (clr_cnt) begin
            stall_cnt_d = '0;
        end else if (contention && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn_h) begin
        if (!rstn_h) begin
            wbe_q       <= 1'b0;
            rdn_q       <= '0;
            rdd_q       <= '0;
            grant_idx_q <= '0;
            stall_cnt_q <= '0;
`ifndef GPR_WB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            wbe_q       <= wbe_d;
            rdn_q       <= rdn_d;
            rdd_q       <= rdd_d;
            grant_idx_q <= grant_idx_d;
            stall_cnt_q <= stall_cnt_d;
`ifndef GPR_WB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign wb_if.wbe = wbe_q;
    assign wb_if.rdn = rdn_q;
    assign wb_if.rdd = rdd_q;
    assign grant_idx = grant_idx_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: reset, single request, round-robin,
// x0 discard, hold/stall and counter saturation/clear. Counter width is 4
// so saturation is reachable in a short run.
module tb_gpr_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int CW = 4;
    localparam int IW = $clog2(NR);

    logic          clk;
    logic          rstn_h;
    logic          clr_cnt;
    logic [IW-1:0] grant_idx;
    logic [CW-1:0] stall_cnt;

    int checks;
    int errors;

    gpr_wb_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    gpr_wb_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_REQ   (NR),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rstn_h   (rstn_h),
        .wb_if    (bus.slave),
        .grant_idx(grant_idx),
        .clr_cnt  (clr_cnt),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] n, input logic [DW-1:0] d);
        bus.req_rdn[i*AW +: AW] = n;
        bus.req_rdd[i*DW +: DW] = d;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        logic [NR-1:0] r;
        @(negedge clk);
        r = bus.req_ready;
        @(posedge clk);
        #1;
        if (r != '0)
            $display("txn t=%0t ready=%b grant=%0d wbe=%0b rdn=%0d rdd=%08h stall=%0d",
                     $time, r, grant_idx, bus.wbe, bus.rdn, bus.rdd, stall_cnt);
    endtask

    initial begin
        int exp_g;
        checks        = 0;
        errors        = 0;
        rstn_h        = 1'b0;
        clr_cnt       = 1'b0;
        bus.req_valid = '0;
        bus.req_rdn   = '0;
        bus.req_rdd   = '0;

        // Reset state
        #2;
        check("rst_wbe",   64'(bus.wbe), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        tick();
        tick();
        rstn_h = 1'b1;

        // Round-robin under full contention
        for (int i = 0; i < NR; i++) set_req(i, AW'(i + 1), DW'(32'hA0 + i));
        bus.req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
`ifdef GPR_WB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = c % 3;
`endif
            #1;
            check("rr_ready", 64'(bus.req_ready), 64'(1 << exp_g));
            tick();
            check("rr_grant", 64'(grant_idx), 64'(exp_g));
            check("rr_wbe",   64'(bus.wbe),   64'd1);
            check("rr_rdn",   64'(bus.rdn),   64'(exp_g + 1));
            check("rr_rdd",   64'(bus.rdd),   64'(32'hA0 + exp_g));
        end
        check("rr_stall", 64'(stall_cnt), 64'd6);

        // Single request from requester 1
        set_req(1, 5'd7, 32'hDEAD_BEEF);
        bus.req_valid = 3'b010;
        #1;
        check("single_ready", 64'(bus.req_ready), 64'b010);
        tick();
        check("single_wbe",   64'(bus.wbe),   64'd1);
        check("single_rdn",   64'(bus.rdn),   64'd7);
        check("single_rdd",   64'(bus.rdd),   64'hDEAD_BEEF);
        check("single_grant", 64'(grant_idx), 64'd1);

        // Idle: wbe drops, payload holds
        bus.req_valid = 3'b000;
        #1;
        check("idle_ready", 64'(bus.req_ready), 64'd0);
        tick();
        check("idle_wbe", 64'(bus.wbe), 64'd0);
        check("idle_rdn", 64'(bus.rdn), 64'd7);
        check("idle_rdd", 64'(bus.rdd), 64'hDEAD_BEEF);

        // x0 write from requester 2: accepted, no write enable
        set_req(2, 5'd0, 32'h1234);
        bus.req_valid = 3'b100;
        #1;
        check("x0_ready", 64'(bus.req_ready), 64'b100);
        tick();
        check("x0_wbe",   64'(bus.wbe),   64'd0);
        check("x0_rdn",   64'(bus.rdn),   64'd0);
        check("x0_rdd",   64'(bus.rdd),   64'h1234);
        check("x0_grant", 64'(grant_idx), 64'd2);

        // Pointer wrapped to 0 after the x0 accept: 1 beats 2
        set_req(1, 5'd9, 32'h9999);
        set_req(2, 5'd10, 32'hAAAA);
        bus.req_valid = 3'b110;
        #1;
        check("ptr_ready", 64'(bus.req_ready), 64'b010);
        tick();
        check("ptr_grant", 64'(grant_idx), 64'd1);
        check("ptr_stall", 64'(stall_cnt), 64'd7);

        // Bring pointer back to 0
        bus.req_valid = 3'b100;
        tick();
        check("wrap_grant", 64'(grant_idx), 64'd2);

        // Hold and stall: 0 and 1 valid at ptr=0, 1 waits one cycle
        set_req(0, 5'd3, 32'h3333);
        set_req(1, 5'd4, 32'h4444);
        bus.req_valid = 3'b011;
        #1;
        check("hold_ready0", 64'(bus.req_ready), 64'b001);
        tick();
        check("hold_grant0", 64'(grant_idx), 64'd0);
        check("hold_rdn0",   64'(bus.rdn),   64'd3);
        check("hold_stall",  64'(stall_cnt), 64'd8);
        bus.req_valid = 3'b010;
        #1;
        check("hold_ready1", 64'(bus.req_ready), 64'b010);
        tick();
        check("hold_grant1", 64'(grant_idx), 64'd1);
        check("hold_rdn1",   64'(bus.rdn),   64'd4);
        check("hold_rdd1",   64'(bus.rdd),   64'h4444);

        // Saturation: 20 contention cycles push 8 past 15
        bus.req_valid = 3'b111;
        for (int c = 0; c < 20; c++) tick();
        check("sat_stall", 64'(stall_cnt), 64'd15);

        // Clear has priority over increment
        clr_cnt = 1'b1;
        tick();
        check("clr_stall", 64'(stall_cnt), 64'd0);
        clr_cnt = 1'b0;
        tick();
        check("post_clr_stall", 64'(stall_cnt), 64'd1);

        // Mid-stream asynchronous reset
        #2;
        rstn_h = 1'b0;
        #1;
        check("mrst_wbe",   64'(bus.wbe),       64'd0);
        check("mrst_rdn",   64'(bus.rdn),       64'd0);
        check("mrst_rdd",   64'(bus.rdd),       64'd0);
        check("mrst_stall", 64'(stall_cnt),     64'd0);
        check("mrst_grant", 64'(grant_idx),     64'd0);
        check("mrst_ready", 64'(bus.req_ready), 64'd0);
        tick();
        check("mrst_hold_wbe", 64'(bus.wbe), 64'd0);
        for (int i = 0; i < NR; i++) set_req(i, AW'(i + 1), DW'(32'hA0 + i));
        rstn_h = 1'b1;
        #1;
        check("rel_ready", 64'(bus.req_ready), 64'b001);
        tick();
        check("rel_grant", 64'(grant_idx), 64'd0);
        check("rel_wbe",   64'(bus.wbe),   64'd1);
        check("rel_rdn",   64'(bus.rdn),   64'd1);

        bus.req_valid = '0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
